// File: rtl/csi2_delay_calib.sv
// csi2_delay_calib: sweeps a common IDELAY tap over all DPHY lanes, scores each tap by packet
// errors and applies the centre of the widest clean window. Option macro: CSI2_CALIB_CORR_AS_ERR_EN.
module csi2_delay_calib #(
   parameter int DATA_LANES    = 2,
   parameter int TAPS          = 32,
   parameter int WINDOW_FRAMES = 4,
   parameter int SETTLE_CYCLES = 16,
   parameter int FRAME_TIMEOUT = 2000000
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic [DATA_LANES-1:0][4:0] skew_i,
   input  logic                       frame_start_i,
   input  logic                       header_err_i,
   input  logic                       corr_header_err_i,
   input  logic                       crc_err_i,
   output logic                       enable_o,
   output logic                       delay_act_o,
   output logic [DATA_LANES-1:0][4:0] lane_delay_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       fail_o,
   output logic [4:0]                 best_tap_o,
   output logic [5:0]                 best_len_o
);
   localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
   localparam int FC_W = $clog2(WINDOW_FRAMES + 1);
   localparam int TO_W = $clog2(FRAME_TIMEOUT + 1);
   localparam logic [4:0] LAST_TAP = 5'(TAPS - 1);

   typedef enum logic [3:0] {IDLE, APPLY, SETTLE, SYNC, MEASURE, EVAL, FINISH, DONE, FAILED} state_t;
   state_t state, state_next;

   logic [DATA_LANES-1:0][4:0] skew_q;
   logic [4:0]      tap;
   logic [SC_W-1:0] settle_cnt;
   logic [TO_W-1:0] timeout_cnt;
   logic [FC_W-1:0] frame_cnt;
   logic [7:0]      err_cnt;
   logic            timed_out;
   logic [4:0]      cur_start, best_start;
   logic [5:0]      cur_len, best_len;

   logic       err_hit, settle_done, to_expired, last_frame, tap_good;
   logic [5:0] len_upd, best_len_m1;
   logic [4:0] start_upd, final_tap;

   // Per-lane tap = common tap plus static skew, clipped at the top of the IDELAY range.
   function automatic logic [DATA_LANES-1:0][4:0] lane_taps(input logic [4:0] t,
                                                             input logic [DATA_LANES-1:0][4:0] sk);
      logic [5:0] sum;
      for (int l = 0; l < DATA_LANES; l++) begin
         sum = {1'b0, t} + {1'b0, sk[l]};
         lane_taps[l] = sum[5] ? 5'd31 : sum[4:0];
      end
   endfunction

   always_comb begin
`ifdef CSI2_CALIB_CORR_AS_ERR_EN
      err_hit = header_err_i | corr_header_err_i | crc_err_i;
`else
      err_hit = (header_err_i & ~corr_header_err_i) | crc_err_i;
`endif
      settle_done = (settle_cnt == SC_W'(SETTLE_CYCLES - 1));
      to_expired  = (timeout_cnt == TO_W'(FRAME_TIMEOUT - 1));
      last_frame  = (frame_cnt == FC_W'(WINDOW_FRAMES - 1));
      tap_good    = ~timed_out & (err_cnt == 8'd0);
      len_upd     = tap_good ? cur_len + 6'd1 : cur_len;
      start_upd   = (tap_good && cur_len == 6'd0) ? tap : cur_start;
      best_len_m1 = best_len - 6'd1;
      final_tap   = (best_len != 6'd0) ? best_start + 5'(best_len_m1 >> 1) : 5'd0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE, FAILED: if (start_i) state_next = APPLY;
         APPLY:   state_next = SETTLE;
         SETTLE:  if (settle_done) state_next = SYNC;
         SYNC: begin
            if (frame_start_i)   state_next = MEASURE;
            else if (to_expired) state_next = EVAL;
         end
         MEASURE: begin
            if (frame_start_i) begin
               if (last_frame) state_next = EVAL;
            end else if (to_expired) begin
               state_next = EVAL;
            end
         end
         EVAL:    state_next = (tap == LAST_TAP) ? FINISH : APPLY;
         FINISH:  state_next = (best_len != 6'd0) ? DONE : FAILED;
         default: state_next = IDLE;
      endcase
   end

   // Datapath and registered outputs; lane_delay_o only ever moves together with delay_act_o.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         skew_q       <= '0;
         tap          <= '0;
         settle_cnt   <= '0;
         timeout_cnt  <= '0;
         frame_cnt    <= '0;
         err_cnt      <= '0;
         timed_out    <= 1'b0;
         cur_start    <= '0;
         cur_len      <= '0;
         best_start   <= '0;
         best_len     <= '0;
         enable_o     <= 1'b0;
         delay_act_o  <= 1'b0;
         lane_delay_o <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         fail_o       <= 1'b0;
         best_tap_o   <= '0;
         best_len_o   <= '0;
      end else begin
         delay_act_o <= 1'b0;
         enable_o    <= state_next inside {SYNC, MEASURE, EVAL, FINISH, DONE, FAILED};
         busy_o      <= !(state_next inside {IDLE, DONE, FAILED});
         done_o      <= (state_next == DONE);
         fail_o      <= (state_next == FAILED);
         case (state)
            IDLE, DONE, FAILED: begin
               if (start_i) begin
                  tap          <= '0;
                  skew_q       <= skew_i;
                  cur_start    <= '0;
                  cur_len      <= '0;
                  best_start   <= '0;
                  best_len     <= '0;
                  lane_delay_o <= lane_taps(5'd0, skew_i);
                  delay_act_o  <= 1'b1;
               end
            end
            APPLY: begin
               settle_cnt  <= '0;
               timeout_cnt <= '0;
               timed_out   <= 1'b0;
            end
            SETTLE: settle_cnt <= settle_cnt + SC_W'(1);
            SYNC: begin
               if (frame_start_i) begin
                  frame_cnt   <= '0;
                  err_cnt     <= '0;
                  timeout_cnt <= '0;
               end else if (to_expired) begin
                  timed_out <= 1'b1;
               end else begin
                  timeout_cnt <= timeout_cnt + TO_W'(1);
               end
            end
            MEASURE: begin
               if (err_hit && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
               if (frame_start_i) begin
                  frame_cnt   <= frame_cnt + FC_W'(1);
                  timeout_cnt <= '0;
               end else if (to_expired) begin
                  timed_out <= 1'b1;
               end else begin
                  timeout_cnt <= timeout_cnt + TO_W'(1);
               end
            end
            EVAL: begin
               // A bad tap or the end of the sweep closes the running window.
               if (!tap_good || tap == LAST_TAP) begin
                  if (len_upd > best_len) begin
                     best_len   <= len_upd;
                     best_start <= start_upd;
                  end
                  cur_len <= '0;
               end else begin
                  cur_len   <= len_upd;
                  cur_start <= start_upd;
               end
               if (tap != LAST_TAP) begin
                  tap          <= tap + 5'd1;
                  lane_delay_o <= lane_taps(tap + 5'd1, skew_q);
                  delay_act_o  <= 1'b1;
               end
            end
            FINISH: begin
               tap          <= final_tap;
               best_tap_o   <= final_tap;
               best_len_o   <= best_len;
               lane_delay_o <= lane_taps(final_tap, skew_q);
               delay_act_o  <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/csi2_delay_calib.md
Name: csi2_delay_calib

Overview:
Controller that sweeps the DPHY IDELAYE2 tap value, applies it to all data lanes and scores each tap by counting packet errors over a fixed number of frames. It picks the centre of the longest contiguous error-free tap window, applies it and reports the result. It sits in the px_clk domain next to csi2_rx and drives its enable_i, delay_act_i and lane_delay_i. Its error and frame-start inputs are single-cycle pulses that are already synchronised to clk_i.

Parameters:
DATA_LANES, 2, number of DPHY data lanes
TAPS, 32, number of taps swept (0..TAPS-1); max 32
WINDOW_FRAMES, 4, frames measured per tap
SETTLE_CYCLES, 16, cycles with enable_o low after each tap change
FRAME_TIMEOUT, 2000000, max cycles to wait for any frame_start_i before the tap is declared bad

Ports:
clk_i  in  1  pixel clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  pulse; starts calibration
skew_i  in  DATA_LANES x 5  per-lane static offset added to the swept tap; sampled on accepted start
frame_start_i  in  1  pulse per frame-start short packet
header_err_i  in  1  pulse; header ECC error
corr_header_err_i  in  1  pulse; header error that was corrected
crc_err_i  in  1  pulse; payload CRC failure
enable_o  out  1  to csi2_rx enable_i
delay_act_o  out  1  one-cycle load strobe for lane_delay_o
lane_delay_o  out  DATA_LANES x 5  IDELAY tap per lane
busy_o  out  1  calibration running
done_o  out  1  high when the result is valid; held until the next start
fail_o  out  1  no good tap found; held until the next start
best_tap_o  out  5  selected common tap
best_len_o  out  6  length of the selected window

Behaviour:
- Reset: all outputs 0. State is IDLE. Tap, counters and window registers are 0.
- lane_delay_o[l] = min(tap + skew_q[l], 31), computed 6 bits wide and saturated. It is registered, so it changes in the same cycle delay_act_o pulses and holds until the next pulse.
- IDLE / DONE / FAIL: start_i moves the FSM to APPLY with tap=0. It also captures skew_i, clears done_o, fail_o and the window registers, and sets busy_o. start_i is ignored while busy_o=1.
- APPLY (1 cycle): enable_o=0 and delay_act_o=1; go to SETTLE.
- SETTLE: enable_o=0 for SETTLE_CYCLES cycles, then go to SYNC.
- SYNC: enable_o=1. On the first frame_start_i go to MEASURE with frame count 0 and error count 0. If FRAME_TIMEOUT cycles pass without one, mark the tap bad and go to EVAL.
- MEASURE:
  - Each cycle with a qualifying error pulse increments an 8-bit error counter that saturates at 255.
  - Each frame_start_i increments the frame count.
  - On the WINDOW_FRAMES-th frame_start_i, go to EVAL. An error pulse in that same cycle is counted.
  - The timeout counter restarts on every frame_start_i; expiry marks the tap bad and goes to EVAL.
  - Error pulses outside MEASURE are ignored.
- Qualifying error = header_err_i & ~corr_header_err_i, or crc_err_i. Several qualifying errors in one cycle count as 1.
- EVAL (1 cycle):
  - A tap is good if it has no timeout and its error count is 0.
  - Good tap: if cur_len=0 then cur_start=tap; cur_len++.
  - Bad tap, or good tap with tap=TAPS-1: if cur_len > best_len then best_start=cur_start and best_len=cur_len (updated lengths included). Then cur_len=0.
  - The comparison is strict, so the earliest of equal-length windows wins.
  - If tap < TAPS-1: tap++ and go to APPLY. Otherwise go to FINAL.
- FINAL: if best_len>0, tap = best_start + ((best_len-1)>>1) and set done_o. Otherwise tap=0 and set fail_o. Pulse delay_act_o, set enable_o=1, clear busy_o and go to DONE or FAIL.
- best_tap_o and best_len_o update in FINAL.
- enable_o stays 1 in DONE and FAIL, and stays 0 in IDLE after reset.
- Reset mid-operation returns everything to the reset values on the next edge. No delay_act_o pulse is issued.

Optional Feature:
Macro CSI2_CALIB_CORR_AS_ERR_EN.
- Defined: corr_header_err_i pulses also qualify as errors, giving a stricter eye.
- Undefined: only uncorrected header errors and CRC errors qualify.

Test Plan:
1. Parameters TAPS=32, WINDOW_FRAMES=2, SETTLE_CYCLES=4, FRAME_TIMEOUT=1000. Periodic frame_start_i, no errors, start -> 32 delay_act_o pulses then one final pulse; best_len_o=32, best_tap_o=15, done_o=1, lane_delay_o={15,15}.
2. crc_err_i injected on taps 0-5 and 20-31, skew_i={0,25} -> window 6..19, best_len_o=14, best_tap_o=12, lane_delay_o[0]=12, lane_delay_o[1]=31 (saturated).
3. Errors on every tap except 2..5 and 10..13 -> best_len_o=4, best_tap_o=3 (earliest window wins).
4. No frame_start_i at all -> each tap times out after 1000 cycles; fail_o=1, done_o=0, best_len_o=0, lane_delay_o={0,0} with skew 0.
5. corr_header_err_i together with header_err_i on taps 0-15 only -> macro defined: best_tap_o=23, best_len_o=16; macro undefined: best_tap_o=15, best_len_o=32.
6. rst_i asserted during MEASURE at tap 7 -> next cycle all outputs 0 and state IDLE; a new start_i sweep begins at tap 0. start_i pulsed while busy_o=1 has no effect.
